modulo_divisor_frequencia_prog: RTL and testbench
=================================================

# modulo_divisor_frequencia_prog

Runtime-programmable, fully synchronous frequency divider and successor to the fixed ripple-T divider chain. All flops share a single `clk`, so the block has no derived clocks. It produces a divided output `clk_div` with a selectable waveform, either square (~50%) or single-cycle pulse. It also produces a one-cycle `tick` clock-enable for downstream logic in the same clock domain. The divisor is loaded through a strobe and acknowledge pair and only changes at period boundaries, so no runt or stretched periods occur.

## Interface
- `WIDTH`, default 20: counter and divisor width. Maximum divisor is 2^WIDTH−1.
- `DIV_RESET`, default 2: divisor in effect after reset. Values below 2 are clamped to 2.

- `clk`  in  1  system clock. All logic is clocked on the rising edge.
- `clr`  in  1  reset, synchronous and active-high.
- `enable`  in  1  count enable.
- `div_in`  in  WIDTH  requested divisor N.
- `div_load`  in  1  one-cycle strobe that captures `div_in`.
- `mode`  in  1  waveform select: 0 = square, 1 = pulse.
- `clk_div`  out  1  divided output, driven from a flop.
- `tick`  out  1  one-cycle pulse in the last cycle of each period.
- `div_ack`  out  1  one-cycle pulse in the first cycle of a period that uses a newly loaded divisor.
- `busy`  out  1  a captured divisor is pending and not yet applied.
- `count`  out  WIDTH  current counter value.

## Operation
- Registered state:
  - `count`
  - `n_act`, the active divisor
  - `mode_act`, the active mode
  - `pend_n` and `busy`
  - `clk_div` and `div_ack` flops
- Counter runs 0..n_act−1 while `enable`=1 and wraps to 0.
- Define `last = (count == n_act−1)`.
- `tick = enable & last`. This is combinational. `tick` is the only output with a path from an input.
- **Clamp:** any divisor below 2 (from `div_in` or `DIV_RESET`) becomes 2.
- **Load:**
  - `div_load`=1 captures the clamped `div_in` into `pend_n` and sets `busy`.
  - A new `div_load` while `busy`=1 overwrites `pend_n`; the latest value wins.
- **Apply:**
  - Apply happens at the edge ending a `tick` cycle.
  - At that edge: `count`←0, `mode_act`←`mode`.
  - If `busy`, or `div_load` is asserted in that same cycle: `n_act`←the pending value (the same-cycle `div_in` takes priority), `busy`←0, `div_ack`←1 for one cycle.
  - `div_load` during the `tick` cycle is therefore applied immediately, and `busy` never asserts for it.
- **Mode:** `mode` is sampled only at wrap. A mode change mid-period takes effect at the next period.
- **clk_div invariant:** in every cycle, `clk_div` reflects the registered state. The flop is loaded with the value computed from the next state.
  - Square (`mode_act`=0): `clk_div = (count < H)`, where H = ⌈n_act/2⌉ = (n_act+1)>>1, computed in WIDTH+1 bits. The output is high for H cycles and low for n_act−H cycles.
  - Pulse (`mode_act`=1): `clk_div = last`.
- **enable=0:**
  - `count`, `clk_div`, `n_act` and `mode_act` hold.
  - `tick`=0.
  - Loads are still captured and `busy` is still set, but nothing is applied until a `tick` occurs.
- **clr=1** overrides everything, including a simultaneous `div_load`:
  - `count`=0, `n_act`=clamped DIV_RESET, `mode_act`=0.
  - `pend_n`=0, `busy`=0, `div_ack`=0.
  - `clk_div`=1 (square, count 0).
  - Any pending load is discarded and no `div_ack` is produced.

## Timing
- **Reset values:** `clk_div`=1, `tick`=0 (when count 0 and n_act≥2), `div_ack`=0, `busy`=0, `count`=0.
- Period is exactly n_act enabled cycles. `tick` has period n_act when enable is held high.
- **Load latency:**
  - `busy` rises in the cycle after `div_load`.
  - `div_ack` and the new `n_act` are visible in the cycle after the next `tick`.
  - Worst case is n_act_old cycles, assuming continuous enable.
- `div_ack` coincides with `count`=0 of the first new period.
- When `busy` was set, `busy` falls in the same cycle that `div_ack` rises.
- No `clk_div` period is ever truncated. Every period uses a single n_act and a single mode_act.

## Test plan
- **Defaults:** WIDTH=20, DIV_RESET=2. Release `clr` with `enable`=1.
  - Required: `count` 0,1,0,1; `clk_div` 1,0,1,0; `tick` high on every `count`=1 cycle.
- **Square, odd divisor:** load 5 with mode 0.
  - Required: `div_ack` in the cycle after `tick`, then `clk_div` high 3 and low 2 repeatedly; `tick` at `count`=4 every 5 cycles.
  - Then load 4 with mode 1. Required: `clk_div` equals `tick`, high at `count`=3 only.
  - Toggle `mode` mid-period. Required: waveform changes only after the wrap.
- **Mid-period load:** n_act=8; `div_load`(3) at `count`=2.
  - Required: `busy`=1 from `count`=3 to 7; `div_ack` with `busy`=0 at next `count`=0; period then 3.
  - Repeat with a second load of 6 at `count`=5. Required: the applied divisor is 6.
- **Same-cycle load and clamp:** `div_load` during a `tick` cycle.
  - Required: applied at that wrap; `busy` stays 0; `div_ack` next cycle.
  - `div_in`=0 and `div_in`=1. Required: effective divisor 2.
  - WIDTH=4, N=15. Required: high 8, low 7.
- **Enable and reset:** `enable`=0 for 10 cycles at `count`=2.
  - Required: `count` and `clk_div` frozen; `tick`=0; a load during the freeze is held in `busy`.
  - `clr` mid-period with `busy`=1. Required: `count`=0, `busy`=0, `n_act`=2, `clk_div`=1, no `div_ack`.

Source files
------------

// File: rtl/modulo_divisor_frequencia_prog.sv
// Runtime-programmable synchronous frequency divider with square or pulse output and a tick enable.
// Divisor updates are captured by strobe and applied only at a period boundary.
module modulo_divisor_frequencia_prog #(
  parameter int WIDTH     = 20,
  parameter int DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             mode,
  output logic             clk_div,
  output logic             tick,
  output logic             div_ack,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2'd2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] N_RESET = (DIV_RESET < 32'sd2) ? DIV_MIN : WIDTH'(DIV_RESET);

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] n);
    if (n < DIV_MIN) begin
      return DIV_MIN;
    end else begin
      return n;
    end
  endfunction

  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] n_act_r, n_act_s;
  logic [WIDTH-1:0] pend_n_r, pend_n_s;
  logic             mode_act_r, mode_act_s;
  logic             busy_r, busy_s;
  logic             div_ack_r, div_ack_s;
  logic             clk_div_r, clk_div_s;
  logic             last_s;
  logic             tick_s;
  logic [WIDTH:0]   half_s;

  assign last_s = (count_r == (n_act_r - ONE));
  assign tick_s = enable & last_s;

  // Next-state: wrap and apply on tick, otherwise count and capture pending loads.
  always_comb begin
    count_s    = count_r;
    n_act_s    = n_act_r;
    pend_n_s   = pend_n_r;
    mode_act_s = mode_act_r;
    busy_s     = busy_r;
    div_ack_s  = 1'b0;
    if (tick_s) begin
      count_s    = '0;
      mode_act_s = mode;
      if (div_load) begin
        n_act_s   = clamp_div(div_in);
        pend_n_s  = clamp_div(div_in);
        busy_s    = 1'b0;
        div_ack_s = 1'b1;
      end else if (busy_r) begin
        n_act_s   = pend_n_r;
        busy_s    = 1'b0;
        div_ack_s = 1'b1;
      end else begin
        busy_s    = 1'b0;
      end
    end else begin
      if (enable) begin
        count_s = count_r + ONE;
      end else begin
        count_s = count_r;
      end
      if (div_load) begin
        pend_n_s = clamp_div(div_in);
        busy_s   = 1'b1;
      end else begin
        pend_n_s = pend_n_r;
      end
    end
  end

  // Waveform computed from next state so the flop always matches the registered count.
  always_comb begin
    half_s = ({1'b0, n_act_s} + {{WIDTH{1'b0}}, 1'b1}) >> 1'b1;
    if (mode_act_s) begin
      clk_div_s = (count_s == (n_act_s - ONE));
    end else begin
      clk_div_s = ({1'b0, count_s} < half_s);
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r    <= '0;
      n_act_r    <= N_RESET;
      pend_n_r   <= '0;
      mode_act_r <= 1'b0;
      busy_r     <= 1'b0;
      div_ack_r  <= 1'b0;
      clk_div_r  <= 1'b1;
    end else begin
      count_r    <= count_s;
      n_act_r    <= n_act_s;
      pend_n_r   <= pend_n_s;
      mode_act_r <= mode_act_s;
      busy_r     <= busy_s;
      div_ack_r  <= div_ack_s;
      clk_div_r  <= clk_div_s;
    end
  end

  assign clk_div = clk_div_r;
  assign tick    = tick_s;
  assign div_ack = div_ack_r;
  assign busy    = busy_r;
  assign count   = count_r;

endmodule

// File: tb/tb_modulo_divisor_frequencia_prog.sv
// Directed bench for modulo_divisor_frequencia_prog: default WIDTH=20 instance plus a WIDTH=4 instance.
module tb_modulo_divisor_frequencia_prog;

  logic        clk;
  logic        clr;
  logic        enable;
  logic [19:0] div_in;
  logic        div_load;
  logic        mode;
  logic        clk_div;
  logic        tick;
  logic        div_ack;
  logic        busy;
  logic [19:0] count;

  logic [3:0]  div_in4;
  logic        div_load4;
  logic        clk_div4;
  logic        tick4;
  logic        div_ack4;
  logic        busy4;
  logic [3:0]  count4;

  int tests = 0;
  int fails = 0;

  modulo_divisor_frequencia_prog dut (
    .clk(clk), .clr(clr), .enable(enable), .div_in(div_in), .div_load(div_load),
    .mode(mode), .clk_div(clk_div), .tick(tick), .div_ack(div_ack), .busy(busy), .count(count)
  );

  modulo_divisor_frequencia_prog #(.WIDTH(4), .DIV_RESET(2)) u4 (
    .clk(clk), .clr(clr), .enable(enable), .div_in(div_in4), .div_load(div_load4),
    .mode(mode), .clk_div(clk_div4), .tick(tick4), .div_ack(div_ack4), .busy(busy4), .count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; enable = 1'b1; div_in = '0; div_load = 1'b0; mode = 1'b0;
    div_in4 = '0; div_load4 = 1'b0;
    step(); step();
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_clk_div", 32'(clk_div), 32'd1);
    chk("rst_tick",    32'(tick),    32'd0);
    chk("rst_ack",     32'(div_ack), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    clr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("dflt_count",   32'(count),   32'(i % 2));
      chk("dflt_clk_div", 32'(clk_div), 32'((i % 2) == 0));
      chk("dflt_tick",    32'(tick),    32'((i % 2) == 1));
    end

    // load 5, square
    div_in = 20'd5; div_load = 1'b1; step(); div_load = 1'b0;
    chk("sq5_busy", 32'(busy), 32'd1);
    chk("sq5_tick", 32'(tick), 32'd1);
    chk("sq5_ack0", 32'(div_ack), 32'd0);
    step();
    chk("sq5_ack",   32'(div_ack), 32'd1);
    chk("sq5_busy0", 32'(busy),    32'd0);
    chk("sq5_cnt0",  32'(count),   32'd0);
    chk("sq5_clk0",  32'(clk_div), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("sq5_count", 32'(count),   32'(i % 5));
      chk("sq5_clk",   32'(clk_div), 32'((i % 5) < 3));
      chk("sq5_tk",    32'(tick),    32'((i % 5) == 4));
      chk("sq5_ackx",  32'(div_ack), 32'd0);
    end

    // load 4, pulse
    div_in = 20'd4; mode = 1'b1; div_load = 1'b1; step(); div_load = 1'b0;
    step(); step(); step();
    chk("p4_busy",  32'(busy),  32'd1);
    chk("p4_cnt4",  32'(count), 32'd4);
    chk("p4_tick4", 32'(tick),  32'd1);
    step();
    chk("p4_ack",  32'(div_ack), 32'd1);
    chk("p4_clk0", 32'(clk_div), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("p4_count", 32'(count),   32'(i % 4));
      chk("p4_clk",   32'(clk_div), 32'((i % 4) == 3));
      chk("p4_tick",  32'(tick),    32'((i % 4) == 3));
    end

    // mode change mid-period takes effect after wrap
    mode = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("mode_clk", 32'(clk_div), (i <= 3) ? 32'(i == 3) : 32'((i % 4) < 2));
    end
    step();

    // mid-period load: n=8, load 3 at count 2
    div_in = 20'd8; div_load = 1'b1; step(); div_load = 1'b0;
    step(); step(); step();
    chk("n8_ack", 32'(div_ack), 32'd1);
    step(); step();
    div_in = 20'd3; div_load = 1'b1; step(); div_load = 1'b0;
    chk("mid_cnt3",  32'(count), 32'd3);
    chk("mid_busy3", 32'(busy),  32'd1);
    for (int i = 4; i <= 7; i++) begin
      step();
      chk("mid_count", 32'(count), 32'(i));
      chk("mid_busy",  32'(busy),  32'd1);
    end
    step();
    chk("mid_ack",   32'(div_ack), 32'd1);
    chk("mid_busy0", 32'(busy),    32'd0);
    chk("mid_cnt0",  32'(count),   32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("n3_count", 32'(count), 32'(i % 3));
      chk("n3_tick",  32'(tick),  32'((i % 3) == 2));
    end

    // two loads in one period: latest (6) wins
    div_in = 20'd8; div_load = 1'b1; step(); div_load = 1'b0;
    step(); step();
    chk("n8b_ack", 32'(div_ack), 32'd1);
    step(); step();
    div_in = 20'd3; div_load = 1'b1; step(); div_load = 1'b0;
    step(); step();
    div_in = 20'd6; div_load = 1'b1; step(); div_load = 1'b0;
    chk("ow_busy", 32'(busy), 32'd1);
    step(); step();
    chk("ow_ack", 32'(div_ack), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("n6_count", 32'(count),   32'(i % 6));
      chk("n6_tick",  32'(tick),    32'((i % 6) == 5));
      chk("n6_clk",   32'(clk_div), 32'((i % 6) < 3));
    end

    // same-cycle load with clamp of 0 and 1
    step(); step(); step(); step(); step();
    chk("sc_tick", 32'(tick), 32'd1);
    div_in = 20'd0; div_load = 1'b1; step(); div_load = 1'b0;
    chk("sc0_ack",  32'(div_ack), 32'd1);
    chk("sc0_busy", 32'(busy),    32'd0);
    chk("sc0_cnt",  32'(count),   32'd0);
    step();
    chk("sc0_tick1", 32'(tick), 32'd1);
    chk("sc0_busyb", 32'(busy), 32'd0);
    div_in = 20'd1; div_load = 1'b1; step(); div_load = 1'b0;
    chk("sc1_ack", 32'(div_ack), 32'd1);
    chk("sc1_cnt", 32'(count),   32'd0);
    step();
    chk("sc1_tick", 32'(tick), 32'd1);

    // enable freeze at count 2 with n=5
    div_in = 20'd5; div_load = 1'b1; step(); div_load = 1'b0;
    step(); step();
    chk("fz_clk_pre", 32'(clk_div), 32'd1);
    enable = 1'b0; #1;
    chk("fz_tick_pre", 32'(tick), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        div_in = 20'd7; div_load = 1'b1;
      end
      step();
      div_load = 1'b0;
      chk("fz_count", 32'(count),   32'd2);
      chk("fz_clk",   32'(clk_div), 32'd1);
      chk("fz_tick",  32'(tick),    32'd0);
      chk("fz_ack",   32'(div_ack), 32'd0);
    end
    chk("fz_busy", 32'(busy), 32'd1);
    enable = 1'b1; step(); step();
    chk("fz_cnt4", 32'(count), 32'd4);
    chk("fz_tk4",  32'(tick),  32'd1);
    enable = 1'b0; #1;
    chk("fz_last_tick", 32'(tick), 32'd0);
    step();
    chk("fz_last_cnt",  32'(count),   32'd4);
    chk("fz_last_busy", 32'(busy),    32'd1);
    chk("fz_last_ack",  32'(div_ack), 32'd0);
    enable = 1'b1; #1;
    chk("fz_tick_re", 32'(tick), 32'd1);
    step();
    chk("fz_ack7",  32'(div_ack), 32'd1);
    chk("fz_busy0", 32'(busy),    32'd0);
    chk("fz_cnt0",  32'(count),   32'd0);

    // clear with a pending load and a simultaneous strobe
    step();
    div_in = 20'd9; div_load = 1'b1; step(); div_load = 1'b0;
    chk("clr_pre_busy", 32'(busy), 32'd1);
    clr = 1'b1; div_load = 1'b1; step();
    chk("clr_count", 32'(count),   32'd0);
    chk("clr_busy",  32'(busy),    32'd0);
    chk("clr_ack",   32'(div_ack), 32'd0);
    chk("clr_clk",   32'(clk_div), 32'd1);
    clr = 1'b0; div_load = 1'b0; step();
    chk("clr_cnt1", 32'(count),   32'd1);
    chk("clr_tk1",  32'(tick),    32'd1);
    chk("clr_ack1", 32'(div_ack), 32'd0);
    step();
    chk("clr_cnt2", 32'(count),   32'd0);
    chk("clr_ack2", 32'(div_ack), 32'd0);
    chk("clr_clk2", 32'(clk_div), 32'd1);

    // WIDTH=4, N=15: half computed without overflow
    div_in4 = 4'd15; div_load4 = 1'b1; step(); div_load4 = 1'b0;
    chk("w4_busy", 32'(busy4), 32'd1);
    step();
    chk("w4_ack", 32'(div_ack4), 32'd1);
    chk("w4_clk0", 32'(clk_div4), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("w4_count", 32'(count4),   32'(i % 15));
      chk("w4_clk",   32'(clk_div4), 32'((i % 15) < 8));
      chk("w4_tick",  32'(tick4),    32'((i % 15) == 14));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
